writeback_arb: RTL and testbench
================================

WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 Parameter XLEN, default 32, datapath and register-file data width.
REQ-002 Parameter DEPTH, default 4, late-result queue entries; power of two, >=2.
REQ-003 Parameter NREG_BITS, default 5, register index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 valid_WB  input  1  pipeline instruction present in writeback.
REQ-007 reg_write_WB  input  1  instruction writes a register.
REQ-008 rd_WB  input  NREG_BITS  destination register.
REQ-009 result_set_WB  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (ALU).
REQ-010 funct3_WB  input  3  load type for extension.
REQ-011 alu_result_WB / mem_data_WB / pcPlus4_WB  input  XLEN each  candidate results; alu_result_WB[1:0] is the load byte offset.
REQ-012 late_valid / late_rd / late_data  input  1 / NREG_BITS / XLEN  multi-cycle unit result offer.
REQ-013 late_ready  output  1  queue accepts a late result this cycle.
REQ-014 stall_WB  output  1  pipeline writeback must hold its inputs this cycle.
REQ-015 rf_we / rf_waddr / rf_wdata  output  1 / NREG_BITS / XLEN  registered register-file write port.

Function
REQ-016 Pipeline write request P = valid_WB & reg_write_WB & (rd_WB != 0) & !stall_WB.
REQ-017 Result mux: 10 -> pcPlus4_WB; 01 -> extended load data; otherwise alu_result_WB.
REQ-018 Load extension: byte = mem_data_WB[8*off +: 8], half = mem_data_WB[16*off[1] +: 16]; funct3 000 sign-extend byte, 001 sign-extend half, 100 zero-extend byte, 101 zero-extend half, 010 and all others full word.
REQ-019 Late push when late_valid & late_ready; late_rd == 0 entries are accepted and discarded (never enqueued).
REQ-020 late_ready = (count < DEPTH); 0 during reset.
REQ-021 Each queue entry holds rd, data, kill bit; FIFO order, pointers wrap modulo DEPTH.
REQ-022 When P occurs, every valid queued entry with rd == rd_WB sets kill (younger pipeline write supersedes older late result); an entry pushed in the same cycle with the same rd is also killed.
REQ-023 Arbitration per cycle: P has priority; queue head drains only when P is absent.
REQ-024 Starvation guard: stall_WB = (count == DEPTH) & valid_WB & reg_write_WB; in that cycle head drains.
REQ-025 Draining a killed head pops it with no write; the next head may drain on the next cycle.
REQ-026 Latency: rf_we/rf_waddr/rf_wdata reflect the winning request one cycle after selection; rf_we = 0 when no write wins.
REQ-027 Simultaneous push and pop: count unchanged; push at count == DEPTH-1 with pop permitted.
REQ-028 rf_waddr is never 0 when rf_we = 1.
REQ-029 stall_WB is combinational from count and pipeline inputs; no combinational path from late_valid to stall_WB.

Reset
REQ-030 While rst_n = 0 at a clock edge: count, pointers, kill bits cleared; rf_we = 0, rf_waddr = 0, rf_wdata = 0; late_ready = 0, stall_WB = 0.
REQ-031 Reset mid-operation discards all queued entries with no write; first accepted write follows the first edge with rst_n = 1.

Verification
REQ-032 LB, off 3, mem_data 0x80_00_00_00, rd 5 -> next cycle rf_we=1, waddr 5, wdata 0xFFFFFF80; LBU same -> 0x00000080; LHU off 2, 0x8001_0000 -> 0x00008001.
REQ-033 DEPTH late pushes with no pipeline writes -> drain one per cycle in order, late_ready high throughout; with pipeline writing every cycle -> queue fills, late_ready=0, stall_WB=1 on next pipeline write while head writes.
REQ-034 Late rd 7 queued, then pipeline writes rd 7 value 0x11 -> rf_wdata 0x11 for rd 7; queued entry popped later with rf_we=0; final rd 7 = 0x11.
REQ-035 Pipeline rd 0, reg_write 1 and late rd 0 -> no rf_we, queue count unchanged.
REQ-036 Queue holding 3 entries, rst_n low one cycle -> rf_we=0, late_ready=0 during reset, count 0 after, no stale writes.

Source files
------------

// File: rtl/writeback_arb.sv
// Writeback arbiter: merges the in-order pipeline writeback with a small FIFO of
// late multi-cycle results onto one registered register-file write port.
module writeback_arb #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_WB,
    input  logic                 reg_write_WB,
    input  logic [NREG_BITS-1:0] rd_WB,
    input  logic [1:0]           result_set_WB,
    input  logic [2:0]           funct3_WB,
    input  logic [XLEN-1:0]      alu_result_WB,
    input  logic [XLEN-1:0]      mem_data_WB,
    input  logic [XLEN-1:0]      pcPlus4_WB,
    input  logic                 late_valid,
    input  logic [NREG_BITS-1:0] late_rd,
    input  logic [XLEN-1:0]      late_data,
    output logic                 late_ready,
    output logic                 stall_WB,
    output logic                 rf_we,
    output logic [NREG_BITS-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]        count;
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [DEPTH-1:0]     q_valid;
    logic [DEPTH-1:0]     q_kill;
    logic [NREG_BITS-1:0] q_rd   [DEPTH];
    logic [XLEN-1:0]      q_data [DEPTH];

    logic            full;
    logic            pipe_we;
    logic            push;
    logic            pop;
    logic            head_we;
    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;

    // Stall depends only on count and pipeline inputs, never on late_valid.
    assign full       = (count == CW'(DEPTH));
    assign late_ready = rst_n & ~full;
    assign stall_WB   = rst_n & full & valid_WB & reg_write_WB;

    assign pipe_we = valid_WB & reg_write_WB & (rd_WB != '0) & ~stall_WB;
    assign push    = late_valid & late_ready & (late_rd != '0);
    assign pop     = (count != '0) & ~pipe_we;
    assign head_we = pop & ~q_kill[rptr];

    assign off     = alu_result_WB[1:0];
    assign ld_byte = mem_data_WB[{off, 3'b000} +: 8];
    assign ld_half = mem_data_WB[{off[1], 4'b0000} +: 16];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_data = mem_data_WB;
        case (funct3_WB)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = mem_data_WB;
        endcase
    end

    always_comb begin
        wb_data = alu_result_WB;
        case (result_set_WB)
            2'b10:   wb_data = pcPlus4_WB;
            2'b01:   wb_data = load_data;
            default: wb_data = alu_result_WB;
        endcase
    end

    // NOTE: queue payload is not reset; q_valid and count alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= late_rd;
            q_data[wptr] <= late_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            q_valid  <= '0;
            q_kill   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // A younger pipeline write supersedes any queued result for the same rd.
            if (pipe_we) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_valid[i] && (q_rd[i] == rd_WB))
                        q_kill[i] <= 1'b1;
                end
            end

            if (push) begin
                q_valid[wptr] <= 1'b1;
                q_kill[wptr]  <= pipe_we && (late_rd == rd_WB);
                wptr          <= wptr + 1'b1;
            end

            if (pop) begin
                q_valid[rptr] <= 1'b0;
                rptr          <= rptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pipe_we) begin
                rf_we    <= 1'b1;
                rf_waddr <= rd_WB;
                rf_wdata <= wb_data;
            end else if (head_we) begin
                rf_we    <= 1'b1;
                rf_waddr <= q_rd[rptr];
                rf_wdata <= q_data[rptr];
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arb.sv
// Directed testbench for writeback_arb: load extension, late-result queue
// draining, starvation stall, kill-on-supersede, rd 0 filtering and reset.
module tb_writeback_arb;

    logic        clk;
    logic        rst_n;
    logic        valid_WB;
    logic        reg_write_WB;
    logic [4:0]  rd_WB;
    logic [1:0]  result_set_WB;
    logic [2:0]  funct3_WB;
    logic [31:0] alu_result_WB;
    logic [31:0] mem_data_WB;
    logic [31:0] pcPlus4_WB;
    logic        late_valid;
    logic [4:0]  late_rd;
    logic [31:0] late_data;
    logic        late_ready;
    logic        stall_WB;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arb #(.XLEN(32), .DEPTH(4), .NREG_BITS(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_WB      (valid_WB),
        .reg_write_WB  (reg_write_WB),
        .rd_WB         (rd_WB),
        .result_set_WB (result_set_WB),
        .funct3_WB     (funct3_WB),
        .alu_result_WB (alu_result_WB),
        .mem_data_WB   (mem_data_WB),
        .pcPlus4_WB    (pcPlus4_WB),
        .late_valid    (late_valid),
        .late_rd       (late_rd),
        .late_data     (late_data),
        .late_ready    (late_ready),
        .stall_WB      (stall_WB),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_WB      = 1'b0;
        reg_write_WB  = 1'b0;
        rd_WB         = '0;
        result_set_WB = 2'b00;
        funct3_WB     = 3'b000;
        alu_result_WB = '0;
        mem_data_WB   = '0;
        pcPlus4_WB    = '0;
        late_valid    = 1'b0;
        late_rd       = '0;
        late_data     = '0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] alu);
        valid_WB      = 1'b1;
        reg_write_WB  = 1'b1;
        rd_WB         = rd;
        result_set_WB = 2'b00;
        alu_result_WB = alu;
    endtask

    task automatic late(input logic [4:0] rd, input logic [31:0] data);
        late_valid = 1'b1;
        late_rd    = rd;
        late_data  = data;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        pipe(5'd3, 32'h1);
        late(5'd4, 32'h2);
        #1;
        n_checks++;
        if ({late_ready, stall_WB} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_comb: ready/stall got %b want 00", {late_ready, stall_WB});
        end
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_rf: got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        idle();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({rf_we, late_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: we/ready got %b want 01", {rf_we, late_ready});
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  rs_v  [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                    2'b00, 2'b11, 2'b10};
        logic [2:0]  f3_v  [10] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b010, 3'b011,
                                    3'b000, 3'b000, 3'b000};
        logic [31:0] alu_v [10] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1, 32'h0, 32'h0,
                                    32'hABC, 32'h55, 32'h0};
        logic [31:0] mem_v [10] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000, 32'h8001_0000,
                                    32'h0000_7F00, 32'h1234_5678, 32'hCAFE_BABE,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp_v [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001,
                                    32'h0000_007F, 32'h1234_5678, 32'hCAFE_BABE,
                                    32'h0000_0ABC, 32'h0000_0055, 32'h0000_1004};
        for (int i = 0; i < 10; i++) begin
            idle();
            pipe(5'd5, alu_v[i]);
            result_set_WB = rs_v[i];
            funct3_WB     = f3_v[i];
            mem_data_WB   = mem_v[i];
            pcPlus4_WB    = 32'h1004;
            tick();
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, exp_v[i]}) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got we=%b a=%0d d=%h want 1/5/%h",
                         i, rf_we, rf_waddr, rf_wdata, exp_v[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_late_drain();
        for (int i = 0; i < 4; i++) begin
            idle();
            late(5'(i + 1), 32'hA0 + i);
            #1;
            n_checks++;
            if (late_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_ready[%0d]: got %b want 1", i, late_ready);
            end
            tick();
            n_checks++;
            if (i == 0) begin
                if (rf_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_first: we got %b want 0", rf_we);
                end
            end else if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(i), 32'hA0 + i - 1}) begin
                n_fail++;
                $display("FAIL drain[%0d]: got we=%b a=%0d d=%h want 1/%0d/%h",
                         i, rf_we, rf_waddr, rf_wdata, i, 32'hA0 + i - 1);
            end
        end
        idle();
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hA3}) begin
            n_fail++;
            $display("FAIL drain_last: got we=%b a=%0d d=%h want 1/4/a3", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: we got %b want 0", rf_we);
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 4; i++) begin
            idle();
            pipe(5'd10, 32'h100 + i);
            late(5'(20 + i), 32'hB0 + i);
            #1;
            n_checks++;
            if ({late_ready, stall_WB} !== 2'b10) begin
                n_fail++;
                $display("FAIL fill_comb[%0d]: ready/stall got %b want 10", i, {late_ready, stall_WB});
            end
            tick();
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h100 + i}) begin
                n_fail++;
                $display("FAIL fill_pipe[%0d]: got we=%b a=%0d d=%h want 1/10/%h",
                         i, rf_we, rf_waddr, rf_wdata, 32'h100 + i);
            end
        end
        idle();
        pipe(5'd10, 32'h200);
        late(5'd30, 32'hEE);
        #1;
        n_checks++;
        if ({late_ready, stall_WB} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_comb: ready/stall got %b want 01", {late_ready, stall_WB});
        end
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 32'hB0}) begin
            n_fail++;
            $display("FAIL stall_drain: got we=%b a=%0d d=%h want 1/20/b0", rf_we, rf_waddr, rf_wdata);
        end
        late_valid = 1'b0;
        #1;
        n_checks++;
        if ({late_ready, stall_WB} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_stall_comb: ready/stall got %b want 10", {late_ready, stall_WB});
        end
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h200}) begin
            n_fail++;
            $display("FAIL held_pipe: got we=%b a=%0d d=%h want 1/10/200", rf_we, rf_waddr, rf_wdata);
        end
        idle();
        for (int j = 1; j < 4; j++) begin
            tick();
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(20 + j), 32'hB0 + j}) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: got we=%b a=%0d d=%h want 1/%0d/%h",
                         j, rf_we, rf_waddr, rf_wdata, 20 + j, 32'hB0 + j);
            end
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_empty: we got %b want 0 (refused entry leaked?)", rf_we);
        end
    endtask

    task automatic test_kill();
        // Each row: pipeline (valid, rd, value), late (valid, rd, data), expected write.
        logic        pv_v [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  prd_v[9] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0};
        logic [31:0] pal_v[9] = '{32'h0, 32'h11, 32'h0, 32'h0, 32'h22, 32'h55, 32'h0, 32'h0, 32'h0};
        logic        lv_v [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  lrd_v[9] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd9, 5'd8, 5'd0, 5'd0, 5'd0};
        logic [31:0] ld_v [9] = '{32'hDEAD, 32'h0, 32'h0, 32'h0, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0};
        logic        ewe_v[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0]  ea_v [9] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd8, 5'd0};
        logic [31:0] ed_v [9] = '{32'h0, 32'h11, 32'h0, 32'h0, 32'h22, 32'h55, 32'h0, 32'h44, 32'h0};
        logic [31:0] last_rd7 = 32'hX;
        for (int i = 0; i < 9; i++) begin
            idle();
            if (pv_v[i]) pipe(prd_v[i], pal_v[i]);
            if (lv_v[i]) late(lrd_v[i], ld_v[i]);
            tick();
            if (rf_we === 1'b1 && rf_waddr === 5'd7) last_rd7 = rf_wdata;
            n_checks++;
            if (ewe_v[i]) begin
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, ea_v[i], ed_v[i]}) begin
                    n_fail++;
                    $display("FAIL kill[%0d]: got we=%b a=%0d d=%h want 1/%0d/%h",
                             i, rf_we, rf_waddr, rf_wdata, ea_v[i], ed_v[i]);
                end
            end else if (rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL kill[%0d]: got we=%b a=%0d d=%h want no write",
                         i, rf_we, rf_waddr, rf_wdata);
            end
        end
        n_checks++;
        if (last_rd7 !== 32'h11) begin
            n_fail++;
            $display("FAIL kill_final_rd7: got %h want 00000011", last_rd7);
        end
    endtask

    task automatic test_zero_rd();
        idle();
        pipe(5'd0, 32'h77);
        late(5'd0, 32'h99);
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rd: we got %b want 0", rf_we);
        end
        idle();
        valid_WB = 1'b1;
        rd_WB    = 5'd3;
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL no_reg_write: we got %b want 0 (rd0 entry enqueued?)", rf_we);
        end
        // Fill three entries while the pipeline keeps the port busy.
        for (int i = 0; i < 3; i++) begin
            idle();
            pipe(5'd1, 32'h300 + i);
            late(5'(12 + i), 32'hC0 + i);
            tick();
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h300 + i}) begin
                n_fail++;
                $display("FAIL q3_pipe[%0d]: got we=%b a=%0d d=%h want 1/1/%h",
                         i, rf_we, rf_waddr, rf_wdata, 32'h300 + i);
            end
        end
        idle();
        #1;
        n_checks++;
        if (late_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL q3_ready: got %b want 1 (count should be 3)", late_ready);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rst_n = 1'b0;
        late(5'd15, 32'hF0);
        #1;
        n_checks++;
        if (late_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b want 0", late_ready);
        end
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_rf: got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_write[%0d]: got we=%b a=%0d want no write", i, rf_we, rf_waddr);
            end
        end
        // Exactly DEPTH pushes fit again, proving the count restarted at zero.
        for (int i = 0; i < 4; i++) begin
            idle();
            pipe(5'd2, 32'h400 + i);
            late(5'(16 + i), 32'hD0 + i);
            #1;
            n_checks++;
            if (late_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL refill_ready[%0d]: got %b want 1", i, late_ready);
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (late_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_full: ready got %b want 0", late_ready);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(16 + j), 32'hD0 + j}) begin
                n_fail++;
                $display("FAIL refill_drain[%0d]: got we=%b a=%0d d=%h want 1/%0d/%h",
                         j, rf_we, rf_waddr, rf_wdata, 16 + j, 32'hD0 + j);
            end
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_empty: we got %b want 0", rf_we);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_load_ext();
        test_late_drain();
        test_fill_stall();
        test_kill();
        test_zero_rd();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
